// File: rtl/dual_clk_fifo_pkg.sv
// dual_clk_fifo_pkg: shared sizes and types for the byte FIFO.
// Provides DATA_W/ADDR_W/CNT_W/DEPTH plus data_t, ptr_t and cnt_t.
package dual_clk_fifo_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/dual_clk_fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage with sync write and registered sync read.
// Ports: clk, rst (clears only the read register), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data (holds when re=0).
module fifo_ram
    import dual_clk_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  ptr_t  waddr,
    input  data_t wdata,
    input  logic  re,
    input  ptr_t  raddr,
    output data_t rdata
);
    data_t mem [DEPTH];

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/dual_clk_fifo.sv
// dual_clk_fifo: byte-wide single-clock FIFO with empty/full flags and occupancy count.
// Ports: clk_w (the clock), clk_r (unused, tie to clk_w source), rst (sync, active-high),
//        buf_in/wr_en write side, rd_en/buf_out read side (data one edge after accept),
//        buf_empty/buf_full flags and fifo_counter (0..DEPTH).
module dual_clk_fifo
    import dual_clk_fifo_pkg::*;
(
    input  logic  clk_w,
    input  logic  clk_r,
    input  logic  rst,
    input  data_t buf_in,
    input  logic  wr_en,
    input  logic  rd_en,
    output data_t buf_out,
    output logic  buf_empty,
    output logic  buf_full,
    output cnt_t  fifo_counter
);
    ptr_t wr_ptr, rd_ptr;
    logic wr_acc, rd_acc;
    logic unused_clk_r;

    assign unused_clk_r = clk_r;
    assign buf_empty    = fifo_counter == '0;
    assign buf_full     = fifo_counter == cnt_t'(DEPTH);
    assign wr_acc       = wr_en & ~buf_full;
    assign rd_acc       = rd_en & ~buf_empty;

    always_ff @(posedge clk_w) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_counter <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            fifo_counter <= (wr_acc & ~rd_acc) ? fifo_counter + 1'b1 :
                            (rd_acc & ~wr_acc) ? fifo_counter - 1'b1 : fifo_counter;
        end
    end

    fifo_ram u_ram (
        .clk   (clk_w),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (buf_in),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (buf_out)
    );
endmodule

// File: tb/tb_dual_clk_fifo.sv
// tb_dual_clk_fifo: directed self-checking bench for dual_clk_fifo.
module tb_dual_clk_fifo;
    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] buf_in, buf_out;
    logic       buf_empty, buf_full;
    logic [7:0] fifo_counter;
    int         passed = 0;
    int         total  = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       rd_ok;

    always #5 clk = ~clk;

    dual_clk_fifo dut (
        .clk_w        (clk),
        .clk_r        (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty", 32'(buf_empty), 1);
        chk("rst_full", 32'(buf_full), 0);
        chk("rst_cnt", 32'(fifo_counter), 0);
        chk("rst_out", 32'(buf_out), 0);

        // Burst write 10..50, then read back
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin buf_in = 8'(10 * i); tick(); end
        wr_en = 1'b0;
        chk("burst_cnt", 32'(fifo_counter), 5);
        rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin tick(); chk("burst_rd", 32'(buf_out), 32'(10 * i)); end
        rd_en = 1'b0;
        chk("burst_empty", 32'(buf_empty), 1);

        // Fill, overflow attempt, drain
        wr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin buf_in = 8'(i); tick(); end
        chk("fill_full", 32'(buf_full), 1);
        chk("fill_cnt", 32'(fifo_counter), 64);
        buf_in = 8'hAA; tick();
        wr_en = 1'b0;
        chk("ovf_cnt", 32'(fifo_counter), 64);
        rd_en = 1'b1;
        for (int i = 0; i < 64; i++) begin tick(); chk("fill_rd", 32'(buf_out), 32'(i)); end
        rd_en = 1'b0;
        chk("fill_empty", 32'(buf_empty), 1);

        // Underflow: reads ignored, buf_out holds 63
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("udf_out", 32'(buf_out), 63);
            chk("udf_cnt", 32'(fifo_counter), 0);
        end
        rd_en = 1'b0;

        // Simultaneous at count 3
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin buf_in = 8'(i); tick(); end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            buf_in = 8'(4 + i); tick();
            chk("sim_cnt", 32'(fifo_counter), 3);
            chk("sim_rd", 32'(buf_out), 32'(1 + i));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); chk("sim_drain", 32'(buf_out), 32'(5 + i)); end
        rd_en = 1'b0;
        chk("sim_empty", 32'(buf_empty), 1);

        // Simultaneous at empty: write only, no write-through
        wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'h77; tick();
        wr_en = 1'b0;
        chk("se_cnt", 32'(fifo_counter), 1);
        chk("se_out", 32'(buf_out), 7);
        tick();
        rd_en = 1'b0;
        chk("se_rd", 32'(buf_out), 32'h77);
        chk("se_empty", 32'(buf_empty), 1);

        // Simultaneous at full: read only, write data dropped
        wr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin buf_in = 8'(100 + i); tick(); end
        chk("sf_full", 32'(buf_full), 1);
        rd_en = 1'b1; buf_in = 8'hEE; tick();
        wr_en = 1'b0;
        chk("sf_cnt", 32'(fifo_counter), 63);
        chk("sf_out", 32'(buf_out), 100);
        for (int i = 1; i < 64; i++) begin tick(); chk("sf_drain", 32'(buf_out), 32'(100 + i)); end
        rd_en = 1'b0;
        chk("sf_empty", 32'(buf_empty), 1);

        // Stream 200 bytes with interleaved reads across wrap
        q.delete();
        for (int i = 0; i < 200; i++) begin
            wr_en = 1'b1; buf_in = 8'(i * 7 + 3); rd_en = (i % 3) != 0;
            rd_ok = rd_en && q.size() > 0;
            if (rd_ok) exp_d = q.pop_front();
            if (q.size() + (rd_ok ? 1 : 0) < 64) q.push_back(buf_in);
            tick();
            if (rd_ok) chk("str_rd", 32'(buf_out), 32'(exp_d));
            chk("str_cnt", 32'(fifo_counter), 32'(q.size()));
        end
        wr_en = 1'b0; rd_en = 1'b1;
        while (q.size() > 0) begin
            exp_d = q.pop_front();
            tick();
            chk("str_drain", 32'(buf_out), 32'(exp_d));
        end
        rd_en = 1'b0;
        chk("str_empty", 32'(buf_empty), 1);

        // Reset with 17 stored entries
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin buf_in = 8'(200 + i); tick(); end
        wr_en = 1'b0;
        chk("mr_cnt17", 32'(fifo_counter), 17);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mr_cnt", 32'(fifo_counter), 0);
        chk("mr_empty", 32'(buf_empty), 1);
        chk("mr_out", 32'(buf_out), 0);
        wr_en = 1'b1; buf_in = 8'h5C; tick();
        wr_en = 1'b0; rd_en = 1'b1; tick();
        rd_en = 1'b0;
        chk("mr_fresh", 32'(buf_out), 32'h5C);
        chk("mr_fresh_empty", 32'(buf_empty), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
